// File: rtl/cr_huf_comp_stcl_sched_if.sv
// Signal bundle between the two symbol-assembly channels, the shared STCL
// builder and the STCL scheduler. The scheduler uses the slave modport; the
// surrounding channels/builder (or a bench) use the master modport.
interface cr_huf_comp_stcl_sched_if #(
    parameter int NUM_SYM     = 33,
    parameter int CL_WIDTH    = 4,
    parameter int HDR_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 4,
    parameter int SIZE_WIDTH  = 8,
    parameter int HCLEN_WIDTH = 4
);
    logic                            req0_valid;
    logic                            req0_deflate;
    logic [NUM_SYM*CL_WIDTH-1:0]     req0_sym_dpth;
    logic                            req0_ready;
    logic                            req0_abort;
    logic                            req1_valid;
    logic                            req1_deflate;
    logic [NUM_SYM*CL_WIDTH-1:0]     req1_sym_dpth;
    logic                            req1_ready;
    logic                            req1_abort;

    logic                            bld_start_build;
    logic                            bld_deflate_mode;
    logic [NUM_SYM*CL_WIDTH-1:0]     bld_sym_dpth;
    logic                            bld_sa_st_read_done;
    logic                            bld_st_lut_wr;
    logic [HDR_WIDTH-1:0]            bld_st_lut_wr_data;
    logic [ADDR_WIDTH-1:0]           bld_st_lut_wr_addr;
    logic                            bld_st_lut_wr_done;
    logic [SIZE_WIDTH-1:0]           bld_st_lut_stcl_size;
    logic [HCLEN_WIDTH-1:0]          bld_st_lut_hclen;

    logic                            lut0_wr;
    logic [HDR_WIDTH-1:0]            lut0_wr_data;
    logic [ADDR_WIDTH-1:0]           lut0_wr_addr;
    logic                            lut1_wr;
    logic [HDR_WIDTH-1:0]            lut1_wr_data;
    logic [ADDR_WIDTH-1:0]           lut1_wr_addr;
    logic                            done0;
    logic                            done1;
    logic [SIZE_WIDTH-1:0]           stcl_size0;
    logic [HCLEN_WIDTH-1:0]          hclen0;
    logic [SIZE_WIDTH-1:0]           stcl_size1;
    logic [HCLEN_WIDTH-1:0]          hclen1;
    logic                            err;

    modport slave (
        input  req0_valid, req0_deflate, req0_sym_dpth, req0_abort,
        input  req1_valid, req1_deflate, req1_sym_dpth, req1_abort,
        input  bld_st_lut_wr, bld_st_lut_wr_data, bld_st_lut_wr_addr,
        input  bld_st_lut_wr_done, bld_st_lut_stcl_size, bld_st_lut_hclen,
        output req0_ready, req1_ready,
        output bld_start_build, bld_deflate_mode, bld_sym_dpth, bld_sa_st_read_done,
        output lut0_wr, lut0_wr_data, lut0_wr_addr,
        output lut1_wr, lut1_wr_data, lut1_wr_addr,
        output done0, done1, stcl_size0, hclen0, stcl_size1, hclen1, err
    );

    modport master (
        output req0_valid, req0_deflate, req0_sym_dpth, req0_abort,
        output req1_valid, req1_deflate, req1_sym_dpth, req1_abort,
        output bld_st_lut_wr, bld_st_lut_wr_data, bld_st_lut_wr_addr,
        output bld_st_lut_wr_done, bld_st_lut_stcl_size, bld_st_lut_hclen,
        input  req0_ready, req1_ready,
        input  bld_start_build, bld_deflate_mode, bld_sym_dpth, bld_sa_st_read_done,
        input  lut0_wr, lut0_wr_data, lut0_wr_addr,
        input  lut1_wr, lut1_wr_data, lut1_wr_addr,
        input  done0, done1, stcl_size0, hclen0, stcl_size1, hclen1, err
    );
endinterface

// File: rtl/cr_huf_comp_stcl_sched.sv
// Two-channel round-robin scheduler for the shared small-tree code-length
// builder. Holds the granted request for the builder, steers LUT writes and
// results back to the owning channel, and turns an owner abort into a timed
// builder drain.
// Optional feature macro: CR_HUF_COMP_STCL_SCHED_WDOG_EN enables a BUSY
// watchdog that reuses the drain counter and pulses err on timeout.
//
// state | meaning
// IDLE  | arbitrate; grant one valid request (ready pulse, capture request)
// LOAD  | one cycle, bld_start_build asserted
// BUSY  | builder running; LUT writes steered to owner, wait for wr_done
// DRAIN | abort/timeout drain, bld_sa_st_read_done held for DRAIN_CYC cycles
module cr_huf_comp_stcl_sched #(
    parameter int NUM_SYM     = 33,
    parameter int CL_WIDTH    = 4,
    parameter int HDR_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 4,
    parameter int SIZE_WIDTH  = 8,
    parameter int HCLEN_WIDTH = 4,
    parameter int DRAIN_CYC   = 80
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cr_huf_comp_stcl_sched_if.slave     bus
);
    localparam int CNT_W = $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DRAIN} state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [CNT_W-1:0]            cnt;
    logic                        cnt_run;
    logic                        owner;
    logic                        grant;
    logic                        grant_ch;
    logic                        own_abort;
    logic                        done_fire;

    logic                        deflate_q;
    logic [NUM_SYM*CL_WIDTH-1:0] sym_dpth_q;
    logic                        lut0_wr_q;
    logic [HDR_WIDTH-1:0]        lut0_data_q;
    logic [ADDR_WIDTH-1:0]       lut0_addr_q;
    logic                        lut1_wr_q;
    logic [HDR_WIDTH-1:0]        lut1_data_q;
    logic [ADDR_WIDTH-1:0]       lut1_addr_q;
    logic                        done0_q;
    logic                        done1_q;
    logic [SIZE_WIDTH-1:0]       size0_q;
    logic [HCLEN_WIDTH-1:0]      hclen0_q;
    logic [SIZE_WIDTH-1:0]       size1_q;
    logic [HCLEN_WIDTH-1:0]      hclen1_q;

`ifdef CR_HUF_COMP_STCL_SCHED_WDOG_EN
    logic                        wdog_fire;
    logic                        err_q;
    // drain counter doubles as the BUSY watchdog timer
    assign cnt_run = (state == DRAIN) || (state == BUSY);
`else
    assign cnt_run = (state == DRAIN);
`endif

    // request decode: round-robin pick (pointer holds the last owner) and owner abort
    always_comb begin
        grant     = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        grant_ch  = (bus.req0_valid && bus.req1_valid) ? ~owner : bus.req1_valid;
        own_abort = owner ? bus.req1_abort : bus.req0_abort;
    end

    // state register and drain/watchdog counter; counter restarts on every state change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt_run)
                cnt <= cnt + 1'b1;
        end
    end

    // next-state logic; an abort coinciding with wr_done skips DRAIN since the builder is already idle
    always_comb begin
        state_nxt = state;
        done_fire = 1'b0;
`ifdef CR_HUF_COMP_STCL_SCHED_WDOG_EN
        wdog_fire = 1'b0;
`endif
        case (state)
            IDLE:  if (grant) state_nxt = LOAD;
            LOAD:  state_nxt = own_abort ? DRAIN : BUSY;
            BUSY: begin
                if (own_abort) begin
                    state_nxt = bus.bld_st_lut_wr_done ? IDLE : DRAIN;
                end else if (bus.bld_st_lut_wr_done) begin
                    state_nxt = IDLE;
                    done_fire = 1'b1;
                end
`ifdef CR_HUF_COMP_STCL_SCHED_WDOG_EN
                else if (cnt == CNT_LAST) begin
                    state_nxt = DRAIN;
                    wdog_fire = 1'b1;
                end
`endif
            end
            DRAIN: if (cnt == CNT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state-decoded outputs, forced low while reset is asserted
    always_comb begin
        bus.req0_ready          = rst_n && grant && !grant_ch;
        bus.req1_ready          = rst_n && grant && grant_ch;
        bus.bld_start_build     = rst_n && (state == LOAD);
        bus.bld_sa_st_read_done = rst_n && (state == DRAIN);
    end

    // grant capture: owner pointer plus request held stable for the builder
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= 1'b1;
            deflate_q  <= 1'b0;
            sym_dpth_q <= '0;
        end else if (grant) begin
            owner      <= grant_ch;
            deflate_q  <= grant_ch ? bus.req1_deflate  : bus.req0_deflate;
            sym_dpth_q <= grant_ch ? bus.req1_sym_dpth : bus.req0_sym_dpth;
        end
    end

    // one registered stage of LUT write steering toward the owner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lut0_wr_q   <= 1'b0;
            lut0_data_q <= '0;
            lut0_addr_q <= '0;
            lut1_wr_q   <= 1'b0;
            lut1_data_q <= '0;
            lut1_addr_q <= '0;
        end else begin
            lut0_wr_q <= (state == BUSY) && bus.bld_st_lut_wr && !owner;
            lut1_wr_q <= (state == BUSY) && bus.bld_st_lut_wr && owner;
            if ((state == BUSY) && bus.bld_st_lut_wr) begin
                if (owner) begin
                    lut1_data_q <= bus.bld_st_lut_wr_data;
                    lut1_addr_q <= bus.bld_st_lut_wr_addr;
                end else begin
                    lut0_data_q <= bus.bld_st_lut_wr_data;
                    lut0_addr_q <= bus.bld_st_lut_wr_addr;
                end
            end
        end
    end

    // completion pulse and result capture for the owner, held until its next completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            size0_q  <= '0;
            hclen0_q <= '0;
            size1_q  <= '0;
            hclen1_q <= '0;
        end else begin
            done0_q <= done_fire && !owner;
            done1_q <= done_fire && owner;
            if (done_fire) begin
                if (owner) begin
                    size1_q  <= bus.bld_st_lut_stcl_size;
                    hclen1_q <= bus.bld_st_lut_hclen;
                end else begin
                    size0_q  <= bus.bld_st_lut_stcl_size;
                    hclen0_q <= bus.bld_st_lut_hclen;
                end
            end
        end
    end

`ifdef CR_HUF_COMP_STCL_SCHED_WDOG_EN
    // watchdog timeout pulse
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= wdog_fire;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.bld_deflate_mode = deflate_q;
    assign bus.bld_sym_dpth     = sym_dpth_q;
    assign bus.lut0_wr          = lut0_wr_q;
    assign bus.lut0_wr_data     = lut0_data_q;
    assign bus.lut0_wr_addr     = lut0_addr_q;
    assign bus.lut1_wr          = lut1_wr_q;
    assign bus.lut1_wr_data     = lut1_data_q;
    assign bus.lut1_wr_addr     = lut1_addr_q;
    assign bus.done0            = done0_q;
    assign bus.done1            = done1_q;
    assign bus.stcl_size0       = size0_q;
    assign bus.hclen0           = hclen0_q;
    assign bus.stcl_size1       = size1_q;
    assign bus.hclen1           = hclen1_q;
endmodule

// File: tb/tb_cr_huf_comp_stcl_sched.sv
// Bench for the STCL scheduler. A planner lays out a randomized timeline of
// builds (grant winners, builder write/done timing, aborts, dropped requests)
// and derives from it, build by build, what every output must be on every
// cycle. The run loop replays the input timeline and compares each cycle.
module tb_cr_huf_comp_stcl_sched;
    localparam int NUM_SYM = 33, CL_WIDTH = 4, HDR_WIDTH = 64, ADDR_WIDTH = 4;
    localparam int SIZE_WIDTH = 8, HCLEN_WIDTH = 4, DRAIN_CYC = 80;
    localparam int DW = NUM_SYM * CL_WIDTH;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cr_huf_comp_stcl_sched_if #(
        .NUM_SYM(NUM_SYM), .CL_WIDTH(CL_WIDTH), .HDR_WIDTH(HDR_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .SIZE_WIDTH(SIZE_WIDTH), .HCLEN_WIDTH(HCLEN_WIDTH)
    ) bus ();

    cr_huf_comp_stcl_sched #(
        .NUM_SYM(NUM_SYM), .CL_WIDTH(CL_WIDTH), .HDR_WIDTH(HDR_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .SIZE_WIDTH(SIZE_WIDTH), .HCLEN_WIDTH(HCLEN_WIDTH),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    // input timeline
    bit                    in_v[2][NCYC];
    bit                    in_ab[2][NCYC];
    bit                    in_defl[2][NCYC];
    logic [DW-1:0]         in_dpth[2][NCYC];
    bit                    in_wr[NCYC];
    bit                    in_wd[NCYC];
    logic [HDR_WIDTH-1:0]  in_data[NCYC];
    logic [ADDR_WIDTH-1:0] in_addr[NCYC];
    logic [SIZE_WIDTH-1:0] in_size[NCYC];
    logic [HCLEN_WIDTH-1:0] in_hclen[NCYC];

    // expected outputs
    bit                    e_ready[2][NCYC];
    bit                    e_start[NCYC];
    bit                    e_rd[NCYC];
    bit                    e_err[NCYC];
    bit                    e_lwr[2][NCYC];
    logic [HDR_WIDTH-1:0]  e_ldata[2][NCYC];
    logic [ADDR_WIDTH-1:0] e_laddr[2][NCYC];
    bit                    e_done[2][NCYC];
    bit                    res_ev[2][NCYC];
    logic [SIZE_WIDTH-1:0] e_size[2][NCYC];
    logic [HCLEN_WIDTH-1:0] e_hclen[2][NCYC];
    bit                    cap_ev[NCYC];
    bit                    e_defl[NCYC];
    logic [DW-1:0]         e_dpth[NCYC];

    int errors = 0;
    int checks = 0;

    function automatic logic [DW-1:0] rand_dpth();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic chk(input string name, input int cyc, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // builder LUT writes on cycles lo..hi land on the owner's lut port one cycle later
    task automatic plan_writes(input int lo, input int hi, input int w);
        for (int c = lo; c <= hi; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                in_wr[c] = 1'b1;
                e_lwr[w][c+1]   = 1'b1;
                e_ldata[w][c+1] = in_data[c];
                e_laddr[w][c+1] = in_addr[c];
            end
        end
    endtask

    task automatic plan();
        int  t, tg, b, d, a, k, s, w, l, nt, dc, r, smax;
        bit  ptr, first, drop;
        bit  pend[2];
        for (int c = 0; c < NCYC; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                in_defl[ch][c] = 1'($urandom_range(0, 1));
                in_dpth[ch][c] = rand_dpth();
            end
            in_data[c]  = {$urandom(), $urandom()};
            in_addr[c]  = ADDR_WIDTH'($urandom());
            in_size[c]  = SIZE_WIDTH'($urandom());
            in_hclen[c] = HCLEN_WIDTH'($urandom());
        end
`ifdef CR_HUF_COMP_STCL_SCHED_WDOG_EN
        smax = 8;
`else
        smax = 7;
`endif
        ptr = 1'b1; first = 1'b1; pend[0] = 1'b0; pend[1] = 1'b0; t = 0;
        while (t < NCYC - 300) begin
            if (first) begin
                tg = 2; pend[0] = 1'b1; pend[1] = 1'b1;
            end else if (!pend[0] && !pend[1]) begin
                tg = t + $urandom_range(0, 3);
                r  = $urandom_range(0, 2);
                pend[0] = (r != 1); pend[1] = (r != 0);
            end else begin
                tg = t;
                if ($urandom_range(0, 2) == 0) begin pend[0] = 1'b1; pend[1] = 1'b1; end
            end
            // round-robin: with both pending the channel that did not win last time wins
            if (pend[0] && pend[1]) w = ptr ? 0 : 1;
            else                    w = pend[1] ? 1 : 0;
            ptr = (w == 1); l = 1 - w;
            in_v[w][tg]    = 1'b1;
            e_ready[w][tg] = 1'b1;
            e_start[tg+1]  = 1'b1;
            cap_ev[tg+1]   = 1'b1;
            e_defl[tg+1]   = in_defl[w][tg];
            e_dpth[tg+1]   = in_dpth[w][tg];
            b = tg + 2;
            k = first ? 3 : $urandom_range(0, 6);
            d = b + k;
            s = first ? 4 : $urandom_range(0, smax);
            if (s <= 1) begin
                a = $urandom_range(tg + 1, d - 1);
                plan_writes(b, a - 1, w);
                in_ab[w][a] = 1'b1;
                for (int i = 1; i <= DRAIN_CYC; i++) e_rd[a+i] = 1'b1;
                nt = a + 1 + DRAIN_CYC;
            end else if (s == 2) begin
                plan_writes(b, d - 1, w);
                in_wd[d] = 1'b1;
                in_ab[w][d] = 1'b1;
                nt = d + 1;
            end else if (s == 8) begin
                // stalled builder: watchdog after DRAIN_CYC busy cycles, then a full drain
                e_err[b+DRAIN_CYC] = 1'b1;
                for (int i = 0; i < DRAIN_CYC; i++) e_rd[b+DRAIN_CYC+i] = 1'b1;
                nt = b + 2 * DRAIN_CYC;
            end else begin
                plan_writes(b, d, w);
                in_wd[d] = 1'b1;
                e_done[w][d+1]  = 1'b1;
                res_ev[w][d+1]  = 1'b1;
                e_size[w][d+1]  = in_size[d];
                e_hclen[w][d+1] = in_hclen[d];
                if (s == 3) in_ab[l][$urandom_range(tg + 1, d)] = 1'b1;
                nt = d + 1;
            end
            if (pend[l]) begin
                drop = !first && ($urandom_range(0, 3) == 0);
                if (drop) begin
                    dc = $urandom_range(tg + 1, nt - 1);
                    for (int c = tg; c < dc; c++) in_v[l][c] = 1'b1;
                    pend[l] = 1'b0;
                end else begin
                    for (int c = tg; c < nt; c++) in_v[l][c] = 1'b1;
                end
            end
            pend[w] = 1'b0;
            t = nt;
            first = 1'b0;
        end
        // held values: captured request and per-channel results persist until the next event
        for (int c = 0; c < NCYC; c++) begin
            if (!cap_ev[c]) begin
                e_defl[c] = (c == 0) ? 1'b0 : e_defl[c-1];
                e_dpth[c] = (c == 0) ? '0   : e_dpth[c-1];
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (!res_ev[ch][c]) begin
                    e_size[ch][c]  = (c == 0) ? '0 : e_size[ch][c-1];
                    e_hclen[ch][c] = (c == 0) ? '0 : e_hclen[ch][c-1];
                end
            end
        end
    endtask

    task automatic drive(input int c);
        bus.req0_valid           = in_v[0][c];
        bus.req0_deflate         = in_defl[0][c];
        bus.req0_sym_dpth        = in_dpth[0][c];
        bus.req0_abort           = in_ab[0][c];
        bus.req1_valid           = in_v[1][c];
        bus.req1_deflate         = in_defl[1][c];
        bus.req1_sym_dpth        = in_dpth[1][c];
        bus.req1_abort           = in_ab[1][c];
        bus.bld_st_lut_wr        = in_wr[c];
        bus.bld_st_lut_wr_data   = in_data[c];
        bus.bld_st_lut_wr_addr   = in_addr[c];
        bus.bld_st_lut_wr_done   = in_wd[c];
        bus.bld_st_lut_stcl_size = in_size[c];
        bus.bld_st_lut_hclen     = in_hclen[c];
    endtask

    task automatic check(input int c);
        chk("req0_ready", c, bus.req0_ready, e_ready[0][c]);
        chk("req1_ready", c, bus.req1_ready, e_ready[1][c]);
        chk("start_build", c, bus.bld_start_build, e_start[c]);
        chk("read_done", c, bus.bld_sa_st_read_done, e_rd[c]);
        chk("err", c, bus.err, e_err[c]);
        chk("deflate_mode", c, bus.bld_deflate_mode, e_defl[c]);
        chk("sym_dpth", c, bus.bld_sym_dpth, e_dpth[c]);
        chk("lut0_wr", c, bus.lut0_wr, e_lwr[0][c]);
        chk("lut1_wr", c, bus.lut1_wr, e_lwr[1][c]);
        if (e_lwr[0][c]) begin
            chk("lut0_data", c, bus.lut0_wr_data, e_ldata[0][c]);
            chk("lut0_addr", c, bus.lut0_wr_addr, e_laddr[0][c]);
        end
        if (e_lwr[1][c]) begin
            chk("lut1_data", c, bus.lut1_wr_data, e_ldata[1][c]);
            chk("lut1_addr", c, bus.lut1_wr_addr, e_laddr[1][c]);
        end
        chk("done0", c, bus.done0, e_done[0][c]);
        chk("done1", c, bus.done1, e_done[1][c]);
        chk("stcl_size0", c, bus.stcl_size0, e_size[0][c]);
        chk("hclen0", c, bus.hclen0, e_hclen[0][c]);
        chk("stcl_size1", c, bus.stcl_size1, e_size[1][c]);
        chk("hclen1", c, bus.hclen1, e_hclen[1][c]);
        // hand-derived timeline of the first two builds (both valid from cycle 2)
        if (c == 2) begin
            chk("pin_first_grant_ch0", c, bus.req0_ready, 1);
            chk("pin_first_not_ch1", c, bus.req1_ready, 0);
        end
        if (c == 3) chk("pin_start_t1", c, bus.bld_start_build, 1);
        if (c == 8) begin
            chk("pin_done0", c, bus.done0, 1);
            chk("pin_second_grant_ch1", c, bus.req1_ready, 1);
        end
        if (c == 9) chk("pin_second_start", c, bus.bld_start_build, 1);
    endtask

    initial begin
        plan();
        drive(0);
        // hostile inputs during reset: nothing may leak to the outputs
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.bld_st_lut_wr = 1'b1; bus.bld_st_lut_wr_done = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", -1, bus.req0_ready, 0);
        chk("rst_req1_ready", -1, bus.req1_ready, 0);
        chk("rst_start", -1, bus.bld_start_build, 0);
        chk("rst_read_done", -1, bus.bld_sa_st_read_done, 0);
        chk("rst_sym_dpth", -1, bus.bld_sym_dpth, 0);
        chk("rst_lut0_wr", -1, bus.lut0_wr, 0);
        chk("rst_lut1_wr", -1, bus.lut1_wr, 0);
        chk("rst_done0", -1, bus.done0, 0);
        chk("rst_done1", -1, bus.done1, 0);
        chk("rst_err", -1, bus.err, 0);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            drive(c);
            @(negedge clk);
            check(c);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
